// File: rtl/exec_sequencer.sv
// exec_sequencer: fetch / issue / wait / writeback sequencer for the RV32IM core.
// It latches one instruction, pulses the ALU start, waits for the ALU ready
// handshake with a stall watchdog, then retires the instruction in a single
// writeback cycle. This cycle gates the PC advance, the register-file write
// and the retired-instruction count.
//
// Handshake: alu_start is a one-cycle request issued from ISSUE. The ALU
// answers by raising alu_ready in some WAIT cycle. The sequencer samples
// alu_ready only in WAIT, and only on the clock edge. alu_ready is ignored in
// every other state. No output depends combinationally on alu_ready or run.
module exec_sequencer #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [31:0]      ins,
  input  logic             ctrl_regwen,
  input  logic             alu_ready,
  output logic [31:0]      ins_q,
  output logic             alu_start,
  output logic             pc_en,
  output logic             reg_wen,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] instret,
  output logic [2:0]       state
);

  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  localparam logic [31:0] INS_NOP    = 32'h0000_0013;
  localparam logic [31:0] INS_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INS_EBREAK = 32'h0010_0073;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_WB    = 3'd4,
    S_HALT  = 3'd5,
    S_FAULT = 3'd6
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [31:0]      r_ins_q;
  logic [TMR_W-1:0] r_timer;
  logic [CNT_W-1:0] r_instret;
  logic             w_is_halt_ins;
  logic             w_timer_last;

  assign w_is_halt_ins = (r_ins_q == INS_ECALL) || (r_ins_q == INS_EBREAK);
  assign w_timer_last  = (r_timer == TMR_LAST);

  // State register. Reset is asynchronous, so an in-flight instruction is
  // dropped at once and produces no writeback side effects.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode. HALT and FAULT are terminal until reset. Encoding 7
  // is unreachable; if it is ever reached, it is treated as a fault.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (run) w_next = S_FETCH;
      S_FETCH: w_next = S_ISSUE;
      S_ISSUE: w_next = w_is_halt_ins ? S_HALT : S_WAIT;
      S_WAIT: begin
        // A ready arriving in the final allowed cycle still retires.
        if (alu_ready)         w_next = S_WB;
        else if (w_timer_last) w_next = S_FAULT;
      end
      S_WB:    w_next = run ? S_FETCH : S_IDLE;
      S_HALT:  w_next = S_HALT;
      S_FAULT: w_next = S_FAULT;
      default: w_next = S_FAULT;
    endcase
  end

  // Datapath registers: the instruction latch, the WAIT watchdog timer and
  // the retired count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ins_q   <= INS_NOP;
      r_timer   <= '0;
      r_instret <= '0;
    end else begin
      if (r_state == S_FETCH) begin
        r_ins_q <= ins;
      end
      if (r_state == S_ISSUE) begin
        r_timer <= '0;
      end else if (r_state == S_WAIT && !alu_ready && !w_timer_last) begin
        r_timer <= r_timer + TMR_W'(1);
      end
      if (r_state == S_WB) begin
        r_instret <= r_instret + CNT_W'(1);
      end
    end
  end

  // Strobes decoded from the registered state only. reg_wen also uses the
  // latched rd field, so that writes to x0 are suppressed.
  always_comb begin
    alu_start = 1'b0;
    pc_en     = 1'b0;
    reg_wen   = 1'b0;
    halted    = 1'b0;
    fault     = 1'b0;
    case (r_state)
      S_ISSUE: alu_start = !w_is_halt_ins;
      S_WB: begin
        pc_en   = 1'b1;
        reg_wen = ctrl_regwen && (r_ins_q[11:7] != 5'd0);
      end
      S_HALT:  halted = 1'b1;
      S_FAULT: fault  = 1'b1;
      default: ;
    endcase
  end

  assign ins_q   = r_ins_q;
  assign instret = r_instret;
  assign state   = r_state;

endmodule
